// File: rtl/query_patch_reader.sv
`default_nettype none
// ============================================================================
// Module   : query_patch_reader
// Purpose  : Reads a burst of `count` patches from a synchronous query-patch
//            memory starting at `base_addr` (address wraps modulo
//            2^ADDR_WIDTH) and streams them out through a 3-entry FIFO with a
//            valid/ready handshake. Reads are issued only while the FIFO plus
//            in-flight reads leave room, so no patch is dropped.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            start, base_addr,   - burst request (accepted only when idle)
//            count
//            csb1, addr1,        - memory read port (csb1 active low, data
//            rpatch1               returns the following cycle)
//            out_valid, out_ready,
//            out_patch, out_idx  - output stream, idx is burst-relative
//            busy, done          - burst status, done is a one-cycle pulse
//            stall_cycles        - backpressure cycle counter
// Options  : QUERY_PATCH_READER_STALL_STATS_EN - when defined, stall_cycles
//            counts cycles with out_valid=1 and out_ready=0 (saturating);
//            otherwise it is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module query_patch_reader #(
    parameter int DATA_WIDTH = 11,
    parameter int PATCH_SIZE = 5,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    input  logic [ADDR_WIDTH:0]              count,
    output logic                             csb1,
    output logic [ADDR_WIDTH-1:0]            addr1,
    input  logic [DATA_WIDTH*PATCH_SIZE-1:0] rpatch1,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*PATCH_SIZE-1:0] out_patch,
    output logic [ADDR_WIDTH:0]              out_idx,
    output logic                             busy,
    output logic                             done,
    output logic [15:0]                      stall_cycles
);

    localparam int c_pw = DATA_WIDTH * PATCH_SIZE;
    localparam logic [ADDR_WIDTH:0] c_one = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state_q,   state_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [ADDR_WIDTH:0]   left_q,    left_d;    // reads still to issue
    logic [ADDR_WIDTH:0]   count_q,   count_d;
    logic [ADDR_WIDTH:0]   idx_q,     idx_d;
    logic                  rd_vld_q,  rd_vld_d;  // read issued last cycle
    logic [c_pw-1:0]       fifo_q [3];
    logic [c_pw-1:0]       fifo_d [3];
    logic [1:0]            wr_ptr_q,  wr_ptr_d;
    logic [1:0]            rd_ptr_q,  rd_ptr_d;
    logic [1:0]            fcnt_q,    fcnt_d;
    logic                  done_q,    done_d;

    logic                  w_start_ok;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_last_hs;
    logic [2:0]            w_occ;

    assign out_valid  = (fcnt_q != 2'd0);
    assign w_pop      = out_valid && out_ready;
    assign w_start_ok = start && (state_q == S_IDLE);
    // Slots already claimed: read returning this cycle plus stored patches.
    // A pop this cycle frees one slot, which keeps full throughput.
    assign w_occ      = {2'b00, rd_vld_q} + {1'b0, fcnt_q};
    assign w_issue    = (state_q == S_ISSUE) && ((w_occ - {2'b00, w_pop}) < 3'd3);
    assign w_last_hs  = w_pop && (idx_q == (count_q - c_one));

    assign csb1      = ~w_issue;
    assign addr1     = addr_q;
    assign out_patch = out_valid ? fifo_q[rd_ptr_q] : '0;
    assign out_idx   = idx_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        left_d   = left_q;
        count_d  = count_q;
        idx_d    = idx_q;
        rd_vld_d = w_issue;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_start_ok) begin
                    addr_d  = base_addr;
                    left_d  = count;
                    count_d = count;
                    idx_d   = '0;
                    if (count != '0) begin
                        state_d = S_ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (w_issue && (left_q == c_one)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_hs) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_issue) begin
            addr_d = addr_q + 1'b1;
            left_d = left_q - c_one;
        end

        // Data for a read issued last cycle is on rpatch1 now.
        if (rd_vld_q) begin
            fifo_d[wr_ptr_q] = rpatch1;
            wr_ptr_d = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
            idx_d    = idx_q + c_one;
        end
        fcnt_d = fcnt_q + {1'b0, rd_vld_q} - {1'b0, w_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            left_q   <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            rd_vld_q <= 1'b0;
            fifo_q   <= '{default: '0};
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            fcnt_q   <= 2'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            left_q   <= left_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            rd_vld_q <= rd_vld_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
            done_q   <= done_d;
        end
    end

`ifdef QUERY_PATCH_READER_STALL_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (w_start_ok) begin
            stall_d = '0;
        end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_query_patch_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_query_patch_reader
// Purpose  : Self-checking bench for query_patch_reader. A memory model
//            answers reads one cycle later; every burst start pushes the
//            expected address sequence and patch/index stream into queues,
//            and a negedge monitor pops and compares whenever the DUT issues
//            a read or completes an output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_query_patch_reader;

    localparam int c_dw    = 11;
    localparam int c_ps    = 5;
    localparam int c_aw    = 9;
    localparam int c_pw    = c_dw * c_ps;
    localparam int c_depth = 1 << c_aw;
`ifdef QUERY_PATCH_READER_STALL_STATS_EN
    localparam int c_exp_stall = 10;
`else
    localparam int c_exp_stall = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [c_aw-1:0]   base_addr;
    logic [c_aw:0]     count;
    logic              csb1;
    logic [c_aw-1:0]   addr1;
    logic [c_pw-1:0]   rpatch1;
    logic              out_valid;
    logic              out_ready;
    logic [c_pw-1:0]   out_patch;
    logic [c_aw:0]     out_idx;
    logic              busy;
    logic              done;
    logic [15:0]       stall_cycles;

    query_patch_reader #(
        .DATA_WIDTH (c_dw),
        .PATCH_SIZE (c_ps),
        .ADDR_WIDTH (c_aw)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .count        (count),
        .csb1         (csb1),
        .addr1        (addr1),
        .rpatch1      (rpatch1),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_patch    (out_patch),
        .out_idx      (out_idx),
        .busy         (busy),
        .done         (done),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [c_pw-1:0] patch;
        logic [c_aw:0]   idx;
    } exp_t;

    logic [c_pw-1:0] mem [c_depth];
    exp_t            exp_q [$];
    logic [c_aw-1:0] addr_q [$];

    int errors   = 0;
    int checks   = 0;
    int outst    = 0;
    int rd_total = 0;
    int hs_total = 0;
    bit rand_rdy = 1'b0;
    bit prev_stall = 1'b0;
    logic [c_pw-1:0] prev_patch;
    logic [c_aw:0]   prev_idx;

    function automatic logic [c_pw-1:0] rnd_patch();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[c_pw-1:0];
    endfunction

    // Synchronous memory: data for a read appears the following cycle;
    // junk otherwise so stale captures are visible.
    always @(posedge clk) begin
        if (!csb1) rpatch1 <= mem[addr1];
        else       rpatch1 <= rnd_patch();
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic flush_model();
        exp_q.delete();
        addr_q.delete();
        outst      = 0;
        prev_stall = 1'b0;
    endtask

    // Drive start for one cycle; the reference stream for an idle DUT is
    // simply mem[(base+i) mod 512] with index i, for i in 0..cnt-1.
    task automatic do_start(input int base, input int cnt);
        start     = 1'b1;
        base_addr = c_aw'(base);
        count     = (c_aw+1)'(cnt);
        for (int i = 0; i < cnt; i++) begin
            exp_t e;
            e.patch = mem[(base + i) % c_depth];
            e.idx   = (c_aw+1)'(i);
            exp_q.push_back(e);
            addr_q.push_back(c_aw'((base + i) % c_depth));
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", max_cyc);
        end
        chk("sb_empty", 64'(exp_q.size()), 64'(0));
        chk("busy_at_done", 64'(busy), 64'(0));
        tick();
        chk("done_one_cycle", 64'(done), 64'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_csb1"},      64'(csb1),         64'(1));
        chk({tag, "_addr1"},     64'(addr1),        64'(0));
        chk({tag, "_out_valid"}, 64'(out_valid),    64'(0));
        chk({tag, "_out_patch"}, 64'(out_patch),    64'(0));
        chk({tag, "_out_idx"},   64'(out_idx),      64'(0));
        chk({tag, "_busy"},      64'(busy),         64'(0));
        chk({tag, "_done"},      64'(done),         64'(0));
        chk({tag, "_stall"},     64'(stall_cycles), 64'(0));
    endtask

    // Monitor: compares each read address and each handshake against the
    // queues, checks hold-stability under backpressure and the bound on
    // reads outstanding (issued but not yet accepted downstream).
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 64'(out_valid), 64'(1));
                    chk("hold_patch", 64'(out_patch), 64'(prev_patch));
                    chk("hold_idx",   64'(out_idx),   64'(prev_idx));
                end
                if (!csb1) begin
                    rd_total++;
                    outst++;
                    if (addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_read: addr1=%0d, no read expected", addr1);
                    end else begin
                        chk("addr1", 64'(addr1), 64'(addr_q.pop_front()));
                    end
                end
                if (out_valid && out_ready) begin
                    hs_total++;
                    outst--;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_patch: idx=%0d, no patch expected", out_idx);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("out_patch", 64'(out_patch), 64'(e.patch));
                        chk("out_idx",   64'(out_idx),   64'(e.idx));
                    end
                end
                if (!csb1) chk("outstanding_over_3", 64'(outst > 3), 64'(0));
                prev_stall = out_valid && !out_ready;
                prev_patch = out_patch;
                prev_idx   = out_idx;
            end
        end
    end

    initial begin
        int b, n, c0, rd0, hs0;
        bit found;
        for (int i = 0; i < c_depth; i++) mem[i] = rnd_patch();
        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Basic burst, full throughput: fixed cycle timeline from start.
        out_ready = 1'b1;
        do_start(0, 5);
        for (int k = 1; k <= 9; k++) begin
            chk("t_busy",      64'(busy),      64'(k <= 7));
            chk("t_csb1",      64'(csb1),      64'(!(k <= 5)));
            chk("t_out_valid", 64'(out_valid), 64'(k >= 3 && k <= 7));
            chk("t_done",      64'(done),      64'(k == 8));
            tick();
        end

        // Address wrap 510,511,0,1 with random backpressure.
        rand_rdy = 1'b1;
        do_start(510, 4);
        wait_done(60);

        // Stall: ready low for 10 cycles of valid, then released.
        rand_rdy  = 1'b0;
        out_ready = 1'b0;
        rd0 = rd_total;
        do_start(100, 6);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (out_valid) found = 1'b1;
            else tick();
        end
        chk("stall_valid_seen", 64'(found), 64'(1));
        repeat (9) tick();
        tick();
        chk("stall_reads_over_3", 64'((rd_total - rd0) > 3), 64'(0));
        chk("stall_cycles", 64'(stall_cycles), 64'(c_exp_stall));
        out_ready = 1'b1;
        wait_done(40);

        // count = 0: done next cycle, no reads, no output.
        do_start(7, 0);
        chk("zero_done",  64'(done),      64'(1));
        chk("zero_busy",  64'(busy),      64'(0));
        chk("zero_csb1",  64'(csb1),      64'(1));
        chk("zero_valid", 64'(out_valid), 64'(0));
        tick();
        chk("zero_done_drop", 64'(done),  64'(0));
        tick();

        // Reset in the middle of a burst of 8 after 3 handshakes.
        hs0 = hs_total;
        do_start(300, 8);
        for (int i = 0; i < 30 && (hs_total - hs0) < 3; i++) tick();
        chk("mid_hs_reached", 64'((hs_total - hs0) >= 3), 64'(1));
        rst = 1'b1;
        flush_model();
        tick();
        rst = 1'b0;
        chk_reset_outputs("midrst");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_done", 64'(done), 64'(0));
        end
        do_start(40, 2);
        wait_done(30);

        // Start re-asserted while busy must be ignored.
        rand_rdy = 1'b1;
        hs0 = hs_total;
        do_start(200, 7);
        for (int r = 0; r < 2; r++) begin
            tick();
            start = 1'b1; base_addr = 9'd17; count = 10'd3;
            tick();
            start = 1'b0;
        end
        wait_done(100);
        chk("busy_start_count", 64'(hs_total - hs0), 64'(7));

        // Random bursts under random backpressure.
        for (int r = 0; r < 6; r++) begin
            b = $urandom_range(0, c_depth - 1);
            n = $urandom_range(1, 24);
            do_start(b, n);
            wait_done(n * 10 + 20);
        end

        // Full-memory burst with wrap from a random base.
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        c0 = $urandom_range(0, c_depth - 1);
        do_start(c0, c_depth);
        wait_done(c_depth + 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
